// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: scoreboard states and FIFO entries.
package regfile_arb_pkg;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        QUEUED,
        GHOST
    } reg_state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          killed;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the writeback, load-issue, load-return, decode-read and regfile-write signals.
interface regfile_write_arbiter_if;
    import regfile_arb_pkg::*;

    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic          iss_ok;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          rd1_busy;
    logic          rd2_busy;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          proto_err;

    modport master (
        output a_we, a_addr, a_data, iss_valid, iss_addr,
               b_valid, b_addr, b_data, ra1, ra2,
        input  iss_ok, b_ready, rd1_busy, rd2_busy, rf_we, rf_wa, rf_wd, proto_err
    );

    modport slave (
        input  a_we, a_addr, a_data, iss_valid, iss_addr,
               b_valid, b_addr, b_data, ra1, ra2,
        output iss_ok, b_ready, rd1_busy, rd2_busy, rf_we, rf_wa, rf_wd, proto_err
    );

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Circular FIFO of returned load data; entries can be marked killed in place so they
// drain later without writing the register file.
module wb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  wb_entry_t     i_pushEntry,
    input  logic          i_pop,
    input  logic          i_killEn,
    input  logic [AW-1:0] i_killAddr,
    output logic          o_full,
    output logic          o_empty,
    output wb_entry_t     o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      r_wrPtr;
    logic [PW:0]      r_rdPtr;
    logic [DEPTH-1:0] r_valid;
    wb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    w_wrIdx;
    logic [PW-1:0]    w_rdIdx;

    assign w_wrIdx = r_wrPtr[PW-1:0];
    assign w_rdIdx = r_rdPtr[PW-1:0];
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[PW] != r_rdPtr[PW]) && (w_wrIdx == w_rdIdx);
    assign o_head  = r_mem[w_rdIdx];

    // Storage holds no reset; the valid bits and pointers decide what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_killEn && r_valid[i] && (r_mem[i].addr == i_killAddr)) begin
                r_mem[i].killed <= 1'b1;
            end
        end
        if (i_push) begin
            r_mem[w_wrIdx] <= i_pushEntry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_valid <= '0;
        end else begin
            if (i_pop) begin
                r_rdPtr          <= r_rdPtr + 1'b1;
                r_valid[w_rdIdx] <= 1'b0;
            end
            if (i_push) begin
                r_wrPtr          <= r_wrPtr + 1'b1;
                r_valid[w_wrIdx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between the primary writeback path and buffered load
// returns, with a per-register load scoreboard driving decode hazard flags.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    regfile_write_arbiter_if.slave bus
);

    reg_state_e r_state [NUM_REGS];
    reg_state_e w_next  [NUM_REGS];
    logic       r_protoErr;
    logic       w_issOk;
    logic       w_full;
    logic       w_empty;
    logic       w_bFire;
    logic       w_push;
    logic       w_pop;
    logic       w_killEn;
    logic       w_protoHit;
    reg_state_e w_bState;
    wb_entry_t  w_head;
    wb_entry_t  w_pushEntry;

    assign w_bState    = r_state[bus.b_addr];
    assign w_bFire     = bus.b_valid && !w_full;
    // A same-cycle A write to the returning register wins; the return is dropped.
    assign w_push      = w_bFire && (w_bState == PENDING)
                         && !(bus.a_we && (bus.a_addr == bus.b_addr));
    assign w_protoHit  = w_bFire && (w_bState == IDLE);
    assign w_pop       = !bus.a_we && !w_empty;
    assign w_killEn    = bus.a_we && (r_state[bus.a_addr] == QUEUED);
    assign w_pushEntry = '{addr: bus.b_addr, data: bus.b_data, killed: 1'b0};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushEntry(w_pushEntry),
        .i_pop      (w_pop),
        .i_killEn   (w_killEn),
        .i_killAddr (bus.a_addr),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_state[r] <= IDLE;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_state[r] <= w_next[r];
            end
        end
    end

    // Scoreboard next state: A write first, then load return / pop, then new issue.
    always_comb begin
        w_issOk = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin : g_sb
            logic       aHit;
            logic       bHit;
            logic       popHit;
            reg_state_e st;
            aHit   = bus.a_we && (bus.a_addr == AW'(r));
            bHit   = w_bFire && (bus.b_addr == AW'(r));
            popHit = w_pop && !w_head.killed && (w_head.addr == AW'(r));
            st     = r_state[r];
            case (r_state[r])
                PENDING: begin
                    if (aHit)      st = bHit ? IDLE : GHOST;
                    else if (bHit) st = QUEUED;
                end
                QUEUED: begin
                    if (aHit || popHit) st = IDLE;
                end
                GHOST: begin
                    if (bHit) st = IDLE;
                end
                default: st = IDLE;
            endcase
            if ((r != 0) && (bus.iss_addr == AW'(r)) && (st == IDLE)) begin
                w_issOk = 1'b1;
                if (bus.iss_valid) st = PENDING;
            end
            w_next[r] = (r == 0) ? IDLE : st;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_protoErr <= 1'b0;
        end else if (w_protoHit) begin
            r_protoErr <= 1'b1;
        end
    end

    // A path has absolute priority; buffered returns drain only in A-idle cycles.
    always_comb begin
        if (bus.a_we) begin
            bus.rf_we = reset && (bus.a_addr != '0);
            bus.rf_wa = bus.a_addr;
            bus.rf_wd = bus.a_data;
        end else begin
            bus.rf_we = reset && !w_empty && !w_head.killed;
            bus.rf_wa = w_head.addr;
            bus.rf_wd = w_head.data;
        end
    end

    assign bus.iss_ok    = w_issOk;
    assign bus.b_ready   = !w_full;
    assign bus.rd1_busy  = (r_state[bus.ra1] == PENDING) || (r_state[bus.ra1] == QUEUED);
    assign bus.rd2_busy  = (r_state[bus.ra2] == PENDING) || (r_state[bus.ra2] == QUEUED);
    assign bus.proto_err = r_protoErr;

endmodule
